// File: rtl/flappy_pkg.sv
// Shared types and screen geometry for the Flappy Bird game controller and renderer.
package flappy_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        DYING = 2'd2,
        OVER  = 2'd3
    } game_state_t;

    localparam int GROUND_Y = 440;
    localparam int BIRD_H   = 24;
    localparam int BIRD_X   = 160;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    // Lowest legal bird top row; the bird rests here when it hits the ground.
    localparam int BIRD_FLOOR = GROUND_Y - BIRD_H;

endpackage

// File: rtl/flappy_game_ctrl_if.sv
// Game controller <-> datapath signals; master drives frame/flap/pipe inputs, slave is the controller.
interface flappy_game_ctrl_if;
    import flappy_pkg::*;

    logic        vsync;
    logic        flap_req;
    logic        collision;
    logic        pipe_passed;
    logic [9:0]  bird_y;
    game_state_t game_state;
    logic        scroll_en;
    logic [15:0] score;
    logic        frame_tick;

    modport master (
        output vsync, flap_req, collision, pipe_passed,
        input  bird_y, game_state, scroll_en, score, frame_tick
    );

    modport slave (
        input  vsync, flap_req, collision, pipe_passed,
        output bird_y, game_state, scroll_en, score, frame_tick
    );

endinterface

// File: rtl/flappy_physics.sv
// Combinational one-frame bird update: velocity with flap/gravity/cap, position with top clamp and ground flag.
module flappy_physics
    import flappy_pkg::*;
#(
    parameter int GRAVITY  = 1,
    parameter int FLAP_VEL = -8,
    parameter int MAX_FALL = 10
) (
    input  logic              [9:0] birdY_i,
    input  logic signed       [7:0] vel_i,
    input  logic                    flap_i,
    output logic              [9:0] birdY_o,
    output logic signed       [7:0] vel_o,
    output logic                    ground_o
);

    localparam logic signed [11:0] FLOOR_S    = 12'(BIRD_FLOOR);
    localparam logic signed [8:0]  MAX_FALL_S = 9'(MAX_FALL);

    logic signed [8:0]  velSum;
    logic signed [7:0]  velNext;
    logic signed [11:0] yNext;

    // Velocity sum is one bit wider so gravity cannot wrap before the cap is applied.
    always_comb begin
        velSum = {vel_i[7], vel_i} + 9'(GRAVITY);
        if (flap_i) begin
            velNext = 8'(FLAP_VEL);
        end else if (velSum > MAX_FALL_S) begin
            velNext = 8'(MAX_FALL);
        end else begin
            velNext = velSum[7:0];
        end

        yNext    = {2'b00, birdY_i} + {{4{velNext[7]}}, velNext};
        birdY_o  = yNext[9:0];
        vel_o    = velNext;
        ground_o = 1'b0;
        if (yNext < 12'sd0) begin
            birdY_o = '0;
            vel_o   = '0;
        end else if (yNext >= FLOOR_S) begin
            birdY_o  = FLOOR_S[9:0];
            ground_o = 1'b1;
        end
    end

endmodule

// File: rtl/flappy_game_ctrl.sv
// Flappy Bird game sequencer: VSYNC frame tick, IDLE/PLAY/DYING/OVER FSM, bird physics and score.
// Optional macro AUTO_FLAP_EN adds a self-flapping frame counter for bring-up without software.
module flappy_game_ctrl
    import flappy_pkg::*;
#(
    parameter int START_Y        = 240,
    parameter int GRAVITY        = 1,
    parameter int FLAP_VEL       = -8,
    parameter int MAX_FALL       = 10,
    parameter int HOLDOFF_FRAMES = 30
`ifdef AUTO_FLAP_EN
    ,
    parameter int AUTO_FLAP_FRAMES = 40
`endif
) (
    input logic               clk,
    input logic               reset_n,
    flappy_game_ctrl_if.slave bus
);

    localparam logic [9:0] START_Y_V    = 10'(START_Y);
    localparam logic [7:0] HOLDOFF_INIT = 8'(HOLDOFF_FRAMES);

    logic               vsync_q,     vsync_d;
    logic               frameTick_q, frameTick_d;
    logic               flapLatch_q, flapLatch_d;
    game_state_t        state_q,     state_d;
    logic        [9:0]  birdY_q,     birdY_d;
    logic signed [7:0]  vel_q,       vel_d;
    logic        [15:0] score_q,     score_d;
    logic        [7:0]  holdoff_q,   holdoff_d;
    logic               scrollEn_q,  scrollEn_d;
`ifdef AUTO_FLAP_EN
    localparam logic [15:0] AUTO_LAST = 16'(AUTO_FLAP_FRAMES - 1);
    logic        [15:0] autoCnt_q,   autoCnt_d;
`endif

    logic               flapEff;
    logic               physFlap;
    logic        [9:0]  physY;
    logic signed [7:0]  physVel;
    logic               physGround;

    // A flap request arriving on the tick cycle is consumed by that same tick.
    assign flapEff  = flapLatch_q | bus.flap_req;
    assign physFlap = (state_q == IDLE) | ((state_q == PLAY) & flapEff);

    flappy_physics #(
        .GRAVITY  (GRAVITY),
        .FLAP_VEL (FLAP_VEL),
        .MAX_FALL (MAX_FALL)
    ) u_physics (
        .birdY_i  (birdY_q),
        .vel_i    (vel_q),
        .flap_i   (physFlap),
        .birdY_o  (physY),
        .vel_o    (physVel),
        .ground_o (physGround)
    );

    always_comb begin
        vsync_d     = bus.vsync;
        frameTick_d = bus.vsync & ~vsync_q;
        flapLatch_d = frameTick_q ? 1'b0 : (flapLatch_q | bus.flap_req);
        state_d     = state_q;
        birdY_d     = birdY_q;
        vel_d       = vel_q;
        score_d     = score_q;
        holdoff_d   = holdoff_q;

        if ((state_q == PLAY) && bus.pipe_passed && (score_q != 16'hFFFF)) begin
            score_d = score_q + 16'd1;
        end

        if (frameTick_q) begin
            unique case (state_q)
                IDLE: begin
                    if (flapEff) begin
                        state_d = PLAY;
                        score_d = '0;
                        birdY_d = physY;
                        vel_d   = physVel;
                    end
                end
                PLAY, DYING: begin
                    birdY_d = physY;
                    vel_d   = physVel;
                    if (physGround) begin
                        state_d   = OVER;
                        vel_d     = '0;
                        holdoff_d = HOLDOFF_INIT;
                    end else if ((state_q == PLAY) && bus.collision) begin
                        state_d = DYING;
                    end
                end
                OVER: begin
                    if (holdoff_q != 8'd0) begin
                        holdoff_d = holdoff_q - 8'd1;
                    end else if (flapEff) begin
                        state_d = IDLE;
                        birdY_d = START_Y_V;
                        vel_d   = '0;
                    end
                end
            endcase
        end

`ifdef AUTO_FLAP_EN
        // Self-set the latch on the tick so the following tick sees a flap.
        autoCnt_d = autoCnt_q;
        if (frameTick_q && ((state_q == IDLE) || (state_q == PLAY))) begin
            if (autoCnt_q == AUTO_LAST) begin
                autoCnt_d   = '0;
                flapLatch_d = 1'b1;
            end else begin
                autoCnt_d = autoCnt_q + 16'd1;
            end
        end
        if ((state_d == IDLE) && (state_q != IDLE)) begin
            autoCnt_d = '0;
        end
`endif

        scrollEn_d = (state_d == PLAY);
    end

    // vsync_q resets high so a VSYNC already high at release is not taken as a new frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vsync_q     <= 1'b1;
            frameTick_q <= 1'b0;
            flapLatch_q <= 1'b0;
            state_q     <= IDLE;
            birdY_q     <= START_Y_V;
            vel_q       <= '0;
            score_q     <= '0;
            holdoff_q   <= '0;
            scrollEn_q  <= 1'b0;
`ifdef AUTO_FLAP_EN
            autoCnt_q   <= '0;
`endif
        end else begin
            vsync_q     <= vsync_d;
            frameTick_q <= frameTick_d;
            flapLatch_q <= flapLatch_d;
            state_q     <= state_d;
            birdY_q     <= birdY_d;
            vel_q       <= vel_d;
            score_q     <= score_d;
            holdoff_q   <= holdoff_d;
            scrollEn_q  <= scrollEn_d;
`ifdef AUTO_FLAP_EN
            autoCnt_q   <= autoCnt_d;
`endif
        end
    end

    assign bus.bird_y     = birdY_q;
    assign bus.game_state = state_q;
    assign bus.scroll_en  = scrollEn_q;
    assign bus.score      = score_q;
    assign bus.frame_tick = frameTick_q;

endmodule
